// File: rtl/act_quant_pkg.sv
// Shared constants and types for the outlier-aware activation quantization path.
package act_quant_pkg;

  // Saturated-mode outlier values.
  localparam logic [31:0] INT32_MAX = 32'h7FFF_FFFF;
  localparam logic [31:0] INT32_MIN = 32'h8000_0000;

  // Field positions shared by the header and outlier entry beats.
  localparam int unsigned CNT_LSB      = 0;
  localparam int unsigned CNT_MSB      = 15;
  localparam int unsigned SAT_SIGN_BIT = 31;

  typedef enum logic [2:0] {
    HDR,
    INL,
    OIDX,
    OVAL,
    OSAT,
    DRAIN
  } dec_state_e;

endpackage

// File: rtl/act_vec_buffer.sv
// Dense frame storage: VEC_LEN elements of 32-bit value plus an outlier flag.
// A whole inlier beat is written at once; outliers overwrite single elements.
module act_vec_buffer #(
  parameter int unsigned VEC_LEN  = 128,
  parameter int unsigned INLIER_W = 8,
  parameter int unsigned PACK     = 32 / INLIER_W,
  parameter int unsigned IDX_W    = $clog2(VEC_LEN),
  parameter int unsigned GRP_W    = ((VEC_LEN / PACK) > 1) ? $clog2(VEC_LEN / PACK) : 1
) (
  input  logic             clk_i,
  input  logic             inl_we_i,
  input  logic [GRP_W-1:0] inl_grp_i,
  input  logic [31:0]      inl_data_i,
  input  logic             out_we_i,
  input  logic [IDX_W-1:0] out_idx_i,
  input  logic [31:0]      out_val_i,
  input  logic             flag_clr_i,
  input  logic [IDX_W-1:0] rd_idx_i,
  output logic [31:0]      rd_val_o,
  output logic             rd_flag_o
);

  logic [31:0] vals [VEC_LEN];
  logic [VEC_LEN-1:0] flags;

  for (genvar e = 0; e < VEC_LEN; e++) begin : g_elem
    localparam int unsigned LANE = e % PACK;
    localparam int unsigned GRP  = e / PACK;

    logic [31:0] val_q;
    logic        flag_q;

    // Element value: an outlier write wins over the inlier lane that maps here.
    always_ff @(posedge clk_i) begin
      if (out_we_i && out_idx_i == IDX_W'(e)) begin
        val_q <= out_val_i;
      end else if (inl_we_i && inl_grp_i == GRP_W'(GRP)) begin
        val_q <= 32'($signed(inl_data_i[LANE*INLIER_W +: INLIER_W]));
      end
    end

    // Outlier flag: cleared by a new header, set by any in-range outlier write.
    always_ff @(posedge clk_i) begin
      if (flag_clr_i) begin
        flag_q <= 1'b0;
      end else if (out_we_i && out_idx_i == IDX_W'(e)) begin
        flag_q <= 1'b1;
      end
    end

    assign vals[e]  = val_q;
    assign flags[e] = flag_q;
  end

  assign rd_val_o  = vals[rd_idx_i];
  assign rd_flag_o = flags[rd_idx_i];

endmodule

// File: rtl/outlier_act_decoder.sv
// Rebuilds a dense activation vector from a header, packed inliers and a sparse
// outlier list, then drains it element by element to the PE array.
module outlier_act_decoder
  import act_quant_pkg::*;
#(
  parameter int unsigned VEC_LEN  = 128,
  parameter int unsigned INLIER_W = 8,
  parameter int unsigned M        = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       s_valid,
  output logic                       s_ready,
  input  logic [31:0]                s_data,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic [31:0]                m_data,
  output logic                       m_outlier,
  output logic [$clog2(VEC_LEN)-1:0] m_idx,
  output logic                       m_last,
  output logic                       err_idx
);

  localparam int unsigned PACK   = 32 / INLIER_W;
  localparam int unsigned NBEATS = VEC_LEN / PACK;
  localparam int unsigned IDX_W  = $clog2(VEC_LEN);
  localparam int unsigned GRP_W  = (NBEATS > 1) ? $clog2(NBEATS) : 1;
  localparam int unsigned CNT_W  = CNT_MSB - CNT_LSB + 1;

  dec_state_e       state_q;
  logic             s_ready_q;
  logic             m_valid_q;
  logic             err_idx_q;
  logic [GRP_W-1:0] beat_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] left_q;
  logic             sat_q;
  logic [IDX_W-1:0] oidx_q;
  logic             oidx_ok_q;
  logic [IDX_W-1:0] rd_idx_q;

  logic             s_fire;
  logic             m_fire;
  logic [CNT_W-1:0] beat_idx;
  logic             beat_idx_ok;
  logic             inl_we;
  logic             out_we;
  logic             flag_clr;
  logic [IDX_W-1:0] out_idx;
  logic [31:0]      out_val;
  logic [31:0]      rd_val;
  logic             rd_flag;

  assign s_fire      = s_valid && s_ready_q;
  assign m_fire      = m_valid_q && m_ready;
  assign beat_idx    = s_data[CNT_MSB:CNT_LSB];
  assign beat_idx_ok = 32'(beat_idx) < VEC_LEN;

  // Buffer write controls decoded from the current state and input handshake.
  always_comb begin
    inl_we   = s_fire && (state_q == INL);
    flag_clr = s_fire && (state_q == HDR);
    out_we   = 1'b0;
    out_idx  = oidx_q;
    out_val  = s_data;
    if (s_fire && (state_q == OVAL) && oidx_ok_q) begin
      out_we = 1'b1;
    end else if (s_fire && (state_q == OSAT) && beat_idx_ok) begin
      out_we  = 1'b1;
      out_idx = beat_idx[IDX_W-1:0];
      out_val = s_data[SAT_SIGN_BIT] ? INT32_MIN : INT32_MAX;
    end
  end

  // Frame FSM, beat/outlier counters and registered handshake outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= HDR;
      s_ready_q <= 1'b1;
      m_valid_q <= 1'b0;
      err_idx_q <= 1'b0;
      beat_q    <= '0;
      cnt_q     <= '0;
      left_q    <= '0;
      sat_q     <= 1'b0;
      oidx_q    <= '0;
      oidx_ok_q <= 1'b0;
      rd_idx_q  <= '0;
    end else begin
      unique case (state_q)
        HDR: if (s_fire) begin
          cnt_q     <= beat_idx;
          left_q    <= beat_idx;
          sat_q     <= 32'(beat_idx) > M;
          err_idx_q <= 1'b0;
          beat_q    <= '0;
          state_q   <= INL;
        end
        INL: if (s_fire) begin
          beat_q <= beat_q + 1'b1;
          if (32'(beat_q) == NBEATS - 1) begin
            beat_q <= '0;
            if (cnt_q == '0) begin
              state_q   <= DRAIN;
              s_ready_q <= 1'b0;
              m_valid_q <= 1'b1;
              rd_idx_q  <= '0;
            end else if (sat_q) begin
              state_q <= OSAT;
            end else begin
              state_q <= OIDX;
            end
          end
        end
        OIDX: if (s_fire) begin
          // Out-of-range index: the value beat is still consumed but not written.
          oidx_q    <= beat_idx[IDX_W-1:0];
          oidx_ok_q <= beat_idx_ok;
          if (!beat_idx_ok) err_idx_q <= 1'b1;
          state_q <= OVAL;
        end
        OVAL: if (s_fire) begin
          left_q <= left_q - 1'b1;
          if (left_q == CNT_W'(1)) begin
            state_q   <= DRAIN;
            s_ready_q <= 1'b0;
            m_valid_q <= 1'b1;
            rd_idx_q  <= '0;
          end else begin
            state_q <= OIDX;
          end
        end
        OSAT: if (s_fire) begin
          left_q <= left_q - 1'b1;
          if (!beat_idx_ok) err_idx_q <= 1'b1;
          if (left_q == CNT_W'(1)) begin
            state_q   <= DRAIN;
            s_ready_q <= 1'b0;
            m_valid_q <= 1'b1;
            rd_idx_q  <= '0;
          end
        end
        DRAIN: if (m_fire) begin
          if (32'(rd_idx_q) == VEC_LEN - 1) begin
            rd_idx_q  <= '0;
            m_valid_q <= 1'b0;
            s_ready_q <= 1'b1;
            state_q   <= HDR;
          end else begin
            rd_idx_q <= rd_idx_q + 1'b1;
          end
        end
        default: state_q <= HDR;
      endcase
    end
  end

  act_vec_buffer #(
    .VEC_LEN  (VEC_LEN),
    .INLIER_W (INLIER_W)
  ) u_buf (
    .clk_i      (clk),
    .inl_we_i   (inl_we),
    .inl_grp_i  (beat_q),
    .inl_data_i (s_data),
    .out_we_i   (out_we),
    .out_idx_i  (out_idx),
    .out_val_i  (out_val),
    .flag_clr_i (flag_clr),
    .rd_idx_i   (rd_idx_q),
    .rd_val_o   (rd_val),
    .rd_flag_o  (rd_flag)
  );

  // Storage is read directly at the drain index; gating keeps the idle outputs at zero
  // and lets the final input beat's write be visible on the first drained element.
  assign s_ready   = s_ready_q;
  assign m_valid   = m_valid_q;
  assign m_idx     = rd_idx_q;
  assign m_data    = m_valid_q ? rd_val : 32'd0;
  assign m_outlier = m_valid_q && rd_flag;
  assign m_last    = m_valid_q && (32'(rd_idx_q) == VEC_LEN - 1);
  assign err_idx   = err_idx_q;

endmodule

// File: tb/tb_outlier_act_decoder.sv
// Scoreboard bench for outlier_act_decoder: a frame-level model pushes expected
// elements, a monitor pops and compares on every drained transfer.
module tb_outlier_act_decoder;

  localparam int VL   = 8;
  localparam int IW   = 8;
  localparam int MM   = 4;
  localparam int PK   = 32 / IW;
  localparam int IDXW = $clog2(VL);

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            s_valid = 1'b0;
  logic            s_ready;
  logic [31:0]     s_data = '0;
  logic            m_valid;
  logic            m_ready = 1'b1;
  logic [31:0]     m_data;
  logic            m_outlier;
  logic [IDXW-1:0] m_idx;
  logic            m_last;
  logic            err_idx;

  outlier_act_decoder #(
    .VEC_LEN  (VL),
    .INLIER_W (IW),
    .M        (MM)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_data    (s_data),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .m_outlier (m_outlier),
    .m_idx     (m_idx),
    .m_last    (m_last),
    .err_idx   (err_idx)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic        flag;
    int          idx;
    logic        last;
    logic        err;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          inl[VL];
  int          e_idx[$];
  logic [31:0] e_val[$];  // normal mode: value; saturated mode: bit 31 is the sign
  int          rdy_mode = 0;
  bit          stalled = 0;
  int          stall_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Downstream ready pattern: always, toggling with a 3-cycle stall at idx 4, or random.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (stall_cnt > 0) begin
        m_ready = 1'b0;
        stall_cnt--;
      end else if (rdy_mode == 0) begin
        m_ready = 1'b1;
      end else if (rdy_mode == 1) begin
        if (m_valid && 32'(m_idx) == 4 && !stalled) begin
          stalled   = 1;
          m_ready   = 1'b0;
          stall_cnt = 2;
        end else begin
          m_ready = ~m_ready;
        end
      end else begin
        m_ready = 1'($urandom_range(0, 1));
      end
    end
  end

  // Monitor: compares each drained element and the handshake rules around it.
  logic            hold = 0;
  logic            prev_mid = 0;
  logic            prev_last = 0;
  logic [31:0]     h_data;
  logic            h_flag;
  logic [IDXW-1:0] h_idx;
  logic            h_last;
  exp_t            x;

  always @(negedge clk) begin
    if (rst) begin
      hold      = 0;
      prev_mid  = 0;
      prev_last = 0;
    end else begin
      if (hold) begin
        check("hold_data", m_data, h_data);
        check("hold_flag", 32'(m_outlier), 32'(h_flag));
        check("hold_idx", 32'(m_idx), 32'(h_idx));
        check("hold_last", 32'(m_last), 32'(h_last));
      end
      if (prev_mid) check("no_bubble", 32'(m_valid), 32'd1);
      if (prev_last) begin
        check("post_last_valid", 32'(m_valid), 32'd0);
        check("post_last_ready", 32'(s_ready), 32'd1);
      end
      prev_mid  = 0;
      prev_last = 0;
      if (m_valid) begin
        check("s_ready_in_drain", 32'(s_ready), 32'd0);
        if (m_ready) begin
          if (exp_q.size() == 0) begin
            check("unexpected_elem", 32'(m_idx), 32'hFFFF_FFFF);
          end else begin
            x = exp_q.pop_front();
            check("elem_data", m_data, x.data);
            check("elem_flag", 32'(m_outlier), 32'(x.flag));
            check("elem_idx", 32'(m_idx), 32'(x.idx));
            check("elem_last", 32'(m_last), 32'(x.last));
            check("elem_err", 32'(err_idx), 32'(x.err));
            prev_mid  = !x.last && (rdy_mode == 0);
            prev_last = x.last;
          end
        end
      end
      hold   = m_valid && !m_ready;
      h_data = m_data;
      h_flag = m_outlier;
      h_idx  = m_idx;
      h_last = m_last;
    end
  end

  task automatic send_beat(input logic [31:0] d);
    int n = 0;
    s_valid = 1'b1;
    s_data  = d;
    while (s_ready !== 1'b1) begin
      @(posedge clk);
      #1;
      n++;
      if (n > 300) begin
        check("s_ready_timeout", 32'(s_ready), 32'd1);
        s_valid = 1'b0;
        return;
      end
    end
    @(posedge clk);
    #1;
    s_valid = 1'b0;
  endtask

  // Sends one frame from inl/e_idx/e_val and pushes the model's expected vector.
  task automatic run_frame(input int cnt, input bit abort_mid);
    logic [31:0] w;
    logic [31:0] t;
    logic [31:0] ev[VL];
    logic        ef[VL];
    logic        err = 0;
    bit          sat = cnt > MM;
    exp_t        y;
    send_beat(32'(cnt));
    check("err_clr_on_hdr", 32'(err_idx), 32'd0);
    for (int k = 0; k < VL / PK; k++) begin
      w = '0;
      for (int j = 0; j < PK; j++) begin
        t = inl[k*PK+j];
        w[j*IW +: IW] = t[IW-1:0];
      end
      send_beat(w);
      if (abort_mid) begin
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_mid_s_ready", 32'(s_ready), 32'd1);
        check("rst_mid_m_valid", 32'(m_valid), 32'd0);
        return;
      end
    end
    for (int i = 0; i < cnt; i++) begin
      t = e_idx[i];
      if (sat) begin
        send_beat({e_val[i][31], 15'd0, t[15:0]});
      end else begin
        send_beat({16'd0, t[15:0]});
        send_beat(e_val[i]);
      end
    end
    for (int e = 0; e < VL; e++) begin
      ev[e] = inl[e];
      ef[e] = 1'b0;
    end
    for (int i = 0; i < cnt; i++) begin
      if (e_idx[i] < VL) begin
        ev[e_idx[i]] = sat ? (e_val[i][31] ? 32'h8000_0000 : 32'h7FFF_FFFF) : e_val[i];
        ef[e_idx[i]] = 1'b1;
      end else begin
        err = 1'b1;
      end
    end
    for (int e = 0; e < VL; e++) begin
      y.data = ev[e];
      y.flag = ef[e];
      y.idx  = e;
      y.last = (e == VL - 1);
      y.err  = err;
      exp_q.push_back(y);
    end
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 1000) begin
      @(posedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      check("drain_timeout", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_scenario1();
    inl = '{1, 2, 3, 4, -1, -2, -3, -4};
    e_idx.delete();
    e_val.delete();
  endtask

  task automatic set_scenario2();
    for (int e = 0; e < VL; e++) inl[e] = 1;
    e_idx = '{3, 6};
    e_val.delete();
    e_val.push_back(32'd500);
    e_val.push_back(-250);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_s_ready", 32'(s_ready), 32'd1);
    check("rst_m_valid", 32'(m_valid), 32'd0);
    check("rst_m_data", m_data, 32'd0);
    check("rst_m_outlier", 32'(m_outlier), 32'd0);
    check("rst_m_idx", 32'(m_idx), 32'd0);
    check("rst_m_last", 32'(m_last), 32'd0);
    check("rst_err_idx", 32'(err_idx), 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // 1: no outliers
    set_scenario1();
    run_frame(0, 0);
    wait_drain();

    // 2: normal mode
    set_scenario2();
    run_frame(2, 0);
    wait_drain();

    // 3: saturated mode
    for (int e = 0; e < VL; e++) inl[e] = int'($urandom_range(0, 255)) - 128;
    e_idx = '{0, 1, 2, 5, 7};
    e_val.delete();
    e_val.push_back(32'h0);
    e_val.push_back(32'h8000_0000);
    e_val.push_back(32'h0);
    e_val.push_back(32'h8000_0000);
    e_val.push_back(32'h0);
    run_frame(5, 0);
    wait_drain();

    // 4: backpressure
    rdy_mode = 1;
    stalled  = 0;
    set_scenario2();
    run_frame(2, 0);
    wait_drain();
    rdy_mode = 0;

    // 5: bad index
    for (int e = 0; e < VL; e++) inl[e] = int'($urandom_range(0, 255)) - 128;
    e_idx = '{9};
    e_val.delete();
    e_val.push_back(32'd77);
    run_frame(1, 0);
    wait_drain();
    check("err_after_drain", 32'(err_idx), 32'd1);

    // 6: reset mid-frame, then a clean frame
    set_scenario1();
    run_frame(0, 1);
    set_scenario1();
    run_frame(0, 0);
    wait_drain();

    // Random frames with random backpressure
    rdy_mode = 2;
    for (int f = 0; f < 12; f++) begin
      int c;
      c = int'($urandom_range(0, 6));
      for (int e = 0; e < VL; e++) inl[e] = int'($urandom_range(0, 255)) - 128;
      e_idx.delete();
      e_val.delete();
      for (int i = 0; i < c; i++) begin
        e_idx.push_back(int'($urandom_range(0, 9)));
        e_val.push_back($urandom);
      end
      run_frame(c, 0);
      wait_drain();
    end
    rdy_mode = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global guard against a hung run.
  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
